guess_entry: RTL

Captures the player's digit entry from the keypad decoder, debounces the enter push-button, and presents the guess as three BCD digits plus a one-cycle confirm strobe. It sits directly upstream of the round/hint comparator. `key0`/`key1`/`key2` and `confirmButton` connect straight to that stage's inputs of the same name. Entry length is bounded by the current difficulty (`Max_digit`).

---
 rtl/guess_entry.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/guess_entry.sv
// Guess entry: collects up to three BCD digits from the keypad, debounces the
// enter button and emits a one-cycle confirm (or error) strobe for the comparator.
module guess_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       digit_valid,
  input  logic [3:0] digit_in,
  input  logic       clear_btn,
  input  logic       enter_btn,
  input  logic [1:0] Max_digit,
  output logic [3:0] key0,
  output logic [3:0] key1,
  output logic [3:0] key2,
  output logic [1:0] digit_count,
  output logic       entry_full,
  output logic       confirmButton,
  output logic       entry_err
);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONFIRM = 2'd1,
    CLEAR   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             debLevel_q, debLevel_d;
  logic             debPrev_q;
  logic [CNT_W-1:0] debCnt_q, debCnt_d;
  logic [3:0]       key0_q, key0_d, key1_q, key1_d, key2_q, key2_d;
  logic [1:0]       count_q, count_d;
  logic             confirm_q, confirm_d;
  logic             err_q, err_d;
  logic [1:0]       maxDigit_q;

  logic press;
  logic maxChange;
  logic entryFull;

  assign press     = debLevel_q & ~debPrev_q;
  assign maxChange = (Max_digit != maxDigit_q);
  assign entryFull = (count_q == maxDigit_q) && (maxDigit_q != 2'd0);

  // The level only toggles after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    debLevel_d = debLevel_q;
    debCnt_d   = '0;
    if (sync2_q != debLevel_q) begin
      if (debCnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        debLevel_d = ~debLevel_q;
      end else begin
        debCnt_d = debCnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    key0_d    = key0_q;
    key1_d    = key1_q;
    key2_d    = key2_q;
    count_d   = count_q;
    confirm_d = 1'b0;
    err_d     = 1'b0;
    if (maxChange) begin
      state_d = ENTRY;
      key0_d  = 4'd0;
      key1_d  = 4'd0;
      key2_d  = 4'd0;
      count_d = 2'd0;
    end else begin
      unique case (state_q)
        ENTRY: begin
          // A press owns its cycle so the keys cannot move under a confirm or error.
          if (press && (maxDigit_q != 2'd0)) begin
            if (entryFull) begin
              state_d   = CONFIRM;
              confirm_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else if (clear_btn) begin
            key0_d  = 4'd0;
            key1_d  = 4'd0;
            key2_d  = 4'd0;
            count_d = 2'd0;
          end else if (digit_valid && (digit_in <= 4'd9) && (count_q < maxDigit_q)) begin
            key2_d  = key1_q;
            key1_d  = key0_q;
            key0_d  = digit_in;
            count_d = count_q + 2'd1;
          end
        end
        CONFIRM: begin
          state_d = CLEAR;
          key0_d  = 4'd0;
          key1_d  = 4'd0;
          key2_d  = 4'd0;
          count_d = 2'd0;
        end
        default: begin
          state_d = ENTRY;
          key0_d  = 4'd0;
          key1_d  = 4'd0;
          key2_d  = 4'd0;
          count_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q    <= ENTRY;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      debLevel_q <= 1'b0;
      debPrev_q  <= 1'b0;
      debCnt_q   <= '0;
      key0_q     <= 4'd0;
      key1_q     <= 4'd0;
      key2_q     <= 4'd0;
      count_q    <= 2'd0;
      confirm_q  <= 1'b0;
      err_q      <= 1'b0;
      maxDigit_q <= Max_digit;
    end else begin
      state_q    <= state_d;
      sync1_q    <= enter_btn;
      sync2_q    <= sync1_q;
      debLevel_q <= debLevel_d;
      debPrev_q  <= debLevel_q;
      debCnt_q   <= debCnt_d;
      key0_q     <= key0_d;
      key1_q     <= key1_d;
      key2_q     <= key2_d;
      count_q    <= count_d;
      confirm_q  <= confirm_d;
      err_q      <= err_d;
      maxDigit_q <= Max_digit;
    end
  end

  assign key0          = key0_q;
  assign key1          = key1_q;
  assign key2          = key2_q;
  assign digit_count   = count_q;
  assign entry_full    = entryFull;
  assign confirmButton = confirm_q;
  assign entry_err     = err_q;

endmodule
